// File: rtl/regfile_pkg.sv
// regfile_pkg: register file geometry and writeback arbiter state shared across the slice
package regfile_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 16;
  typedef enum logic {ARB, LOCKED} wb_arb_state_t;
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: one-hot grant of the first set request found scanning upward from ptr with wrap
module wb_rr_pick #(
  parameter int N = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) gnt = N'(1) << ((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port among NUM_REQ requesters with lock support.
// WB_ARB_RR_EN selects round-robin priority; undefined gives fixed priority (index 0 wins).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wb_en,
  output logic [ADDR_W-1:0]         wb_dest,
  output logic [DATA_W-1:0]         wb_value,
  output logic [2**ADDR_W-1:0]      pending_mask,
  output logic                      locked
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int NR = 2**ADDR_W;
  wb_arb_state_t state_q, state_d;
  logic [PW-1:0] owner_q, owner_d, sel, ptr;
  logic [NUM_REQ-1:0] gnt;
  logic fire;
  logic wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_value_q, wb_value_d;
`ifdef WB_ARB_RR_EN
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  assign ptr = rr_ptr_q;
  always_comb rr_ptr_d = (state_q == ARB && fire) ? ((int'(sel) == NUM_REQ - 1) ? '0 : sel + PW'(1)) : rr_ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
`else
  assign ptr = '0;
`endif
  wb_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (.req(req_valid), .ptr(ptr), .gnt(gnt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ARB;
      owner_q <= '0;
      wb_en_q <= 1'b0;
      wb_dest_q <= '0;
      wb_value_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wb_en_q <= wb_en_d;
      wb_dest_q <= wb_dest_d;
      wb_value_q <= wb_value_d;
    end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (state_q == ARB && fire && req_lock[sel]) begin
      state_d = LOCKED;
      owner_d = sel;
    end else if (state_q == LOCKED && !req_lock[owner_q]) state_d = ARB;
  end
  // In LOCKED only the owner can win, and only when it actually has a write
  assign req_ready = !rst_n ? '0 : (state_q == LOCKED) ? (req_valid & (NUM_REQ'(1) << owner_q)) : gnt;
  assign fire = |req_ready;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) sel = PW'(i);
    wb_en_d = fire;
    wb_dest_d = fire ? req_dest[sel*ADDR_W +: ADDR_W] : wb_dest_q;
    wb_value_d = fire ? req_value[sel*DATA_W +: DATA_W] : wb_value_q;
  end
  assign wb_en = wb_en_q;
  assign wb_dest = wb_dest_q;
  assign wb_value = wb_value_q;
  assign pending_mask = wb_en_q ? (NR'(1) << wb_dest_q) : '0;
  assign locked = state_q == LOCKED;
endmodule
